slew_limiter_mc: RTL and testbench

Multi-channel, parametrised rate-of-change (slew) limiter for the discrete-audio models. It has separate rise and fall limits and a fractional accumulator, so slow slew rates do not truncate to zero. It sits between a discrete stage's sample output and the mixer. One shared subtract/compare datapath is time-multiplexed across channels, once per audio sample strobe.

---
 rtl/slew_limiter_pkg.sv | 16 +
 rtl/slew_limiter_step_unit.sv | 35 +++
 rtl/slew_limiter_mc.sv | 144 ++++++++++++++
 tb/tb_slew_limiter_mc.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slew_limiter_pkg.sv
// Shared types and elaboration helpers for the multi-channel slew limiter.
package slew_limiter_pkg;

    typedef enum logic [1:0] {IDLE, RUN, COMMIT} fsm_t;

    function automatic longint calc_step(
        input longint rate,
        input longint vcc,
        input longint sample_rate,
        input int     width,
        input int     frac
    );
        return (rate << (width - 2 + frac)) / vcc / sample_rate;
    endfunction

endpackage

// File: rtl/slew_limiter_step_unit.sv
// Per-channel slew step: moves the accumulator toward the target by at most
// one rise/fall step, landing exactly on the target when within reach.
module slew_step_unit
    import slew_limiter_pkg::*;
#(
    parameter int AW = 20
) (
    input  logic signed [AW-1:0] acc,
    input  logic signed [AW-1:0] target,
    input  logic signed [AW-1:0] rise_step,
    input  logic signed [AW-1:0] fall_step,
    input  logic                 bypass,
    output logic signed [AW-1:0] next_acc
);

    logic signed [AW:0] diff;
    logic signed [AW:0] rise_x;
    logic signed [AW:0] fall_x;

    // One extra bit so a full-scale swing cannot wrap the difference.
    always_comb begin
        diff     = $signed({target[AW-1], target}) - $signed({acc[AW-1], acc});
        rise_x   = $signed({rise_step[AW-1], rise_step});
        fall_x   = $signed({fall_step[AW-1], fall_step});
        next_acc = target;
        if (bypass) begin
            next_acc = target;
        end else if (diff > rise_x) begin
            next_acc = acc + rise_step;
        end else if (diff < -fall_x) begin
            next_acc = acc - fall_step;
        end
    end

endmodule

// File: rtl/slew_limiter_mc.sv
// Time-multiplexed multi-channel slew limiter: one channel per clock after
// each sample strobe, then all outputs committed together.
module slew_limiter_mc
    import slew_limiter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 4,
    parameter int VCC         = 12,
    parameter int SAMPLE_RATE = 48000,
    parameter int RISE_RATE   = 1000,
    parameter int FALL_RATE   = 1000,
    parameter int FRAC_BITS   = 4
) (
    input  logic                      clk,
    input  logic                      I_RST,
    input  logic                      audio_clk_en,
    input  logic                      bypass,
    input  logic                      clear_overrun,
    input  logic [CHANNELS*WIDTH-1:0] in,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int AW = WIDTH + FRAC_BITS;
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam longint RISE_L = calc_step(RISE_RATE, VCC, SAMPLE_RATE,
                                          WIDTH, FRAC_BITS);
    localparam longint FALL_L = calc_step(FALL_RATE, VCC, SAMPLE_RATE,
                                          WIDTH, FRAC_BITS);

    localparam logic signed [AW-1:0] RISE_STEP = AW'(RISE_L);
    localparam logic signed [AW-1:0] FALL_STEP = AW'(FALL_L);

    if (RISE_L == 0 || FALL_L == 0) begin : g_bad_step
        $fatal(1, "slew_limiter_mc: rise/fall step rounds to zero");
    end

    fsm_t                      state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      byp_q, byp_d;
    logic signed [WIDTH-1:0]   snap_q [CHANNELS];
    logic signed [WIDTH-1:0]   snap_d [CHANNELS];
    logic signed [AW-1:0]      acc_q  [CHANNELS];
    logic signed [AW-1:0]      acc_d  [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] out_q, out_d;
    logic                      valid_q, valid_d;
    logic                      ovr_q, ovr_d;

    logic signed [AW-1:0]      cur_acc;
    logic signed [AW-1:0]      cur_tgt;
    logic signed [AW-1:0]      step_next;

    assign cur_acc = acc_q[idx_q];
    assign cur_tgt = AW'(snap_q[idx_q]) <<< FRAC_BITS;

    slew_step_unit #(.AW(AW)) u_step (
        .acc       (cur_acc),
        .target    (cur_tgt),
        .rise_step (RISE_STEP),
        .fall_step (FALL_STEP),
        .bypass    (byp_q),
        .next_acc  (step_next)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        byp_d   = byp_q;
        snap_d  = snap_q;
        acc_d   = acc_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;
        if (clear_overrun) begin
            ovr_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (audio_clk_en) begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        snap_d[k] = in[k*WIDTH +: WIDTH];
                    end
                    byp_d   = bypass;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[idx_q] = step_next;
                if (idx_q == IW'(CHANNELS - 1)) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            COMMIT: begin
                // Slicing off the fraction is a floor for two's complement.
                for (int k = 0; k < CHANNELS; k++) begin
                    out_d[k*WIDTH +: WIDTH] = acc_q[k][AW-1:FRAC_BITS];
                end
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new overrun beats a simultaneous clear.
        if (audio_clk_en && state_q != IDLE) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            byp_q   <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                snap_q[k] <= '0;
                acc_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byp_q   <= byp_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            snap_q  <= snap_d;
            acc_q   <= acc_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_slew_limiter_mc.sv
// Directed and randomized checks of slew_limiter_mc against a clamp-based
// reference model (2 channels, rise step 455, fall step 910).
module tb_slew_limiter_mc;

    localparam int W  = 16;
    localparam int CH = 2;
    localparam longint RS = 455;
    localparam longint FS = 910;

    logic          clk = 1'b0;
    logic          I_RST = 1'b1;
    logic          audio_clk_en = 1'b0;
    logic          bypass = 1'b0;
    logic          clear_overrun = 1'b0;
    logic [CH*W-1:0] in_v = '0;
    logic [CH*W-1:0] out_v;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int failures = 0;
    longint macc [CH];

    always #5 clk = ~clk;

    slew_limiter_mc #(
        .WIDTH(16), .CHANNELS(CH), .VCC(12), .SAMPLE_RATE(48000),
        .RISE_RATE(1000), .FALL_RATE(2000), .FRAC_BITS(4)
    ) dut (
        .clk(clk), .I_RST(I_RST), .audio_clk_en(audio_clk_en),
        .bypass(bypass), .clear_overrun(clear_overrun),
        .in(in_v), .out(out_v), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the new accumulator is the target clamped into the window
    // [acc - FS, acc + RS]; bypass jumps straight to the target.
    function automatic longint model_next(longint acc, longint x, bit byp);
        longint t = x * 16;
        longint lo = acc - FS;
        longint hi = acc + RS;
        if (byp) return t;
        if (t > hi) return hi;
        if (t < lo) return lo;
        return t;
    endfunction

    function automatic longint mout(longint acc);
        longint q = acc / 16;
        if (acc < 0 && (q * 16 != acc)) q = q - 1;
        return q;
    endfunction

    function automatic logic signed [31:0] dout(int k);
        logic signed [W-1:0] v = out_v[k*W +: W];
        return 32'(v);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_sample(input int a, input int b, input bit byp);
        macc[0] = model_next(macc[0], a, byp);
        macc[1] = model_next(macc[1], b, byp);
    endtask

    task automatic sample(input int a, input int b, input bit byp,
                          input string tag);
        int n;
        in_v = {16'(b), 16'(a)};
        bypass = byp;
        audio_clk_en = 1'b1;
        cycle();
        audio_clk_en = 1'b0;
        in_v = $urandom;
        bypass = 1'($urandom);
        check({tag, "_busy"}, 32'(busy), 1);
        model_sample(a, b, byp);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!out_valid && n < 20);
        check({tag, "_lat"}, n, 3);
        check({tag, "_out0"}, dout(0), 32'(mout(macc[0])));
        check({tag, "_out1"}, dout(1), 32'(mout(macc[1])));
        check({tag, "_idle"}, 32'(busy), 0);
        cycle();
        check({tag, "_pulse"}, 32'(out_valid), 0);
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        I_RST = 1'b1;
        repeat (2) cycle();
        I_RST = 1'b0;
        macc[0] = 0;
        macc[1] = 0;
    endtask

    initial begin
        int exp_r [4] = '{28, 56, 85, 113};
        int exp_f [3] = '{943, 886, 829};
        int cnt;
        int prev;
        int d;
        int ra;
        int rb;

        // Reset state
        macc[0] = 0;
        macc[1] = 0;
        repeat (3) cycle();
        check("rst_out0", dout(0), 0);
        check("rst_out1", dout(1), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_ovr", 32'(overrun), 0);
        I_RST = 1'b0;
        cycle();

        // Rise ramp on both channels toward 1000
        for (int i = 0; i < 38; i++) begin
            sample(1000, 1000, 1'b0, "rise");
            if (i < 4) check("rise_const", dout(0), exp_r[i]);
        end
        check("rise_land0", dout(0), 1000);
        check("rise_land1", dout(1), 1000);

        // Fall asymmetry on ch1, ch0 held
        for (int i = 0; i < 19; i++) begin
            sample(1000, 0, 1'b0, "fall");
            if (i < 3) check("fall_const", dout(1), exp_f[i]);
            check("fall_ch0", dout(0), 1000);
        end
        check("fall_land1", dout(1), 0);

        // Small-step exact landing from acc=0
        do_reset();
        sample(20, -5, 1'b0, "small");
        check("small_const", dout(0), 20);

        // Bypass to negative full scale, then limited rise without wrap
        sample(-32768, 0, 1'b1, "byp");
        check("byp_const", dout(0), -32768);
        for (int i = 0; i < 10; i++) begin
            prev = dout(0);
            sample(32767, 0, 1'b0, "ext");
            d = dout(0) - prev;
            check("ext_step", 32'((d > 0) && (d <= 29)), 1);
        end

        // Overrun: second strobe one cycle after the first
        in_v = {16'(-300), 16'(500)};
        bypass = 1'b0;
        audio_clk_en = 1'b1;
        cycle();
        cycle();
        audio_clk_en = 1'b0;
        model_sample(500, -300, 1'b0);
        check("ovr_set", 32'(overrun), 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cnt += int'(out_valid);
            cycle();
        end
        check("ovr_one_valid", cnt, 1);
        check("ovr_out0", dout(0), 32'(mout(macc[0])));
        check("ovr_out1", dout(1), 32'(mout(macc[1])));
        clear_overrun = 1'b1;
        cycle();
        clear_overrun = 1'b0;
        check("ovr_clear", 32'(overrun), 0);

        // Strobe coinciding with COMMIT is dropped
        audio_clk_en = 1'b1;
        cycle();
        audio_clk_en = 1'b0;
        model_sample(500, -300, 1'b0);
        cycle();
        cycle();
        audio_clk_en = 1'b1;
        cycle();
        audio_clk_en = 1'b0;
        check("commit_valid", 32'(out_valid), 1);
        check("commit_ovr", 32'(overrun), 1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            cnt += int'(out_valid);
        end
        check("commit_dropped", cnt, 0);
        check("commit_out0", dout(0), 32'(mout(macc[0])));

        // Clear and new overrun in the same cycle: set wins
        clear_overrun = 1'b1;
        cycle();
        clear_overrun = 1'b0;
        check("ovr_clear2", 32'(overrun), 0);
        audio_clk_en = 1'b1;
        cycle();
        clear_overrun = 1'b1;
        cycle();
        audio_clk_en = 1'b0;
        clear_overrun = 1'b0;
        model_sample(500, -300, 1'b0);
        check("ovr_setwins", 32'(overrun), 1);
        repeat (6) cycle();
        check("setwins_out1", dout(1), 32'(mout(macc[1])));

        // Reset mid-RUN
        in_v = {16'(3000), 16'(3000)};
        audio_clk_en = 1'b1;
        cycle();
        audio_clk_en = 1'b0;
        I_RST = 1'b1;
        cycle();
        I_RST = 1'b0;
        macc[0] = 0;
        macc[1] = 0;
        check("mid_out0", dout(0), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_ovr", 32'(overrun), 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cnt += int'(out_valid);
            cycle();
        end
        check("mid_no_valid", cnt, 0);
        sample(100, -100, 1'b0, "after_rst");
        check("after_rst0", dout(0), 28);
        check("after_rst1", dout(1), -57);

        // Randomized samples against the model
        for (int i = 0; i < 30; i++) begin
            ra = int'($signed(16'($urandom)));
            rb = int'($signed(16'($urandom)));
            sample(ra, rb, ($urandom_range(3) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
